// File: rtl/cmp_minmax_seq_if.sv
// Operand stream and comparator bus used by the min/max sequencer.
// master: the sequencer side. slave: operand source plus external comparator.
interface cmp_minmax_seq_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic [3:0] cmp_A;
    logic [3:0] cmp_B;
    logic [3:0] cmp_Opcode;
    logic [3:0] cmp_out;

    modport master (
        input  in_valid,
        input  in_data,
        input  cmp_out,
        output in_ready,
        output cmp_A,
        output cmp_B,
        output cmp_Opcode
    );

    modport slave (
        output in_valid,
        output in_data,
        output cmp_out,
        input  in_ready,
        input  cmp_A,
        input  cmp_B,
        input  cmp_Opcode
    );
endinterface

// File: rtl/cmp_minmax_seq.sv
// Min/max sequencer: streams COUNT signed 4-bit operands through an external
// combinational comparator and keeps the running signed max/min and the
// index of each. Strict comparisons keep the earliest index on ties.
module cmp_minmax_seq #(
    parameter int COUNT = 8,
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    cmp_minmax_seq_if.master   bus,
    output logic [3:0]         max_val,
    output logic [IDX_W-1:0]   max_idx,
    output logic [3:0]         min_val,
    output logic [IDX_W-1:0]   min_idx,
    output logic               done
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_CMP_GT = 3'd2;
    localparam logic [2:0] ST_CMP_LT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam logic [3:0] OP_NONE = 4'b0000;
    localparam logic [3:0] OP_GT   = 4'b1110;
    localparam logic [3:0] OP_LT   = 4'b1111;

    localparam logic [IDX_W-1:0] IDX_ZERO   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_ONE    = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] COUNT_LAST = IDX_W'(COUNT);

    logic [2:0]       state_r;
    logic [IDX_W-1:0] counter_r;
    logic [3:0]       elem_r;
    logic [3:0]       max_val_r;
    logic [3:0]       min_val_r;
    logic [IDX_W-1:0] max_idx_r;
    logic [IDX_W-1:0] min_idx_r;
    logic             done_r;

    logic             busy_s;
    logic             in_ready_s;
    logic [3:0]       cmp_a_s;
    logic [3:0]       cmp_b_s;
    logic [3:0]       cmp_op_s;
    logic             cmp_hit_s;
    logic             cmp_unused_s;

    // Only the comparator result LSB carries meaning; upper bits are don't-care.
    assign cmp_hit_s    = bus.cmp_out[0];
    assign cmp_unused_s = ^bus.cmp_out[3:1];

    // Decode handshake and comparator drive directly from the state register.
    always_comb begin
        busy_s     = (state_r != ST_IDLE);
        in_ready_s = (state_r == ST_LOAD);
        cmp_a_s    = 4'b0000;
        cmp_b_s    = 4'b0000;
        cmp_op_s   = OP_NONE;
        case (state_r)
            ST_CMP_GT: begin
                cmp_a_s  = elem_r;
                cmp_b_s  = max_val_r;
                cmp_op_s = OP_GT;
            end
            ST_CMP_LT: begin
                cmp_a_s  = elem_r;
                cmp_b_s  = min_val_r;
                cmp_op_s = OP_LT;
            end
            default: begin
                cmp_a_s  = 4'b0000;
                cmp_b_s  = 4'b0000;
                cmp_op_s = OP_NONE;
            end
        endcase
    end

    assign busy           = busy_s;
    assign bus.in_ready   = in_ready_s;
    assign bus.cmp_A      = cmp_a_s;
    assign bus.cmp_B      = cmp_b_s;
    assign bus.cmp_Opcode = cmp_op_s;

    assign max_val = max_val_r;
    assign max_idx = max_idx_r;
    assign min_val = min_val_r;
    assign min_idx = min_idx_r;
    assign done    = done_r;

    // Sequencer FSM, operand capture and running max/min update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            counter_r <= IDX_ZERO;
            elem_r    <= 4'b0000;
            max_val_r <= 4'b0000;
            min_val_r <= 4'b0000;
            max_idx_r <= IDX_ZERO;
            min_idx_r <= IDX_ZERO;
            done_r    <= 1'b0;
        end else begin
            // done is high only on the cycle the FSM sits in DONE.
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        counter_r <= IDX_ZERO;
                        state_r   <= ST_LOAD;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        counter_r <= counter_r + IDX_ONE;
                        if (counter_r == IDX_ZERO) begin
                            // First operand seeds both extremes.
                            max_val_r <= bus.in_data;
                            min_val_r <= bus.in_data;
                            max_idx_r <= IDX_ZERO;
                            min_idx_r <= IDX_ZERO;
                            if (COUNT == 1) begin
                                state_r <= ST_DONE;
                                done_r  <= 1'b1;
                            end else begin
                                state_r <= ST_LOAD;
                            end
                        end else begin
                            elem_r  <= bus.in_data;
                            state_r <= ST_CMP_GT;
                        end
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_CMP_GT: begin
                    if (cmp_hit_s) begin
                        max_val_r <= elem_r;
                        max_idx_r <= counter_r - IDX_ONE;
                    end else begin
                        max_val_r <= max_val_r;
                    end
                    state_r <= ST_CMP_LT;
                end
                ST_CMP_LT: begin
                    if (cmp_hit_s) begin
                        min_val_r <= elem_r;
                        min_idx_r <= counter_r - IDX_ONE;
                    end else begin
                        min_val_r <= min_val_r;
                    end
                    if (counter_r == COUNT_LAST) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmp_minmax_seq.sv
// Directed bench for cmp_minmax_seq: table of whole jobs plus hand-written
// reset-abort and single-operand sequences. The bench models the external
// comparator, with random junk on comp_out[3:1].
module tb_cmp_minmax_seq;

    logic clk;
    logic reset;
    logic start;
    logic start1;
    logic busy, busy1, done, done1;
    logic [3:0] max_val, min_val, max_val1, min_val1;
    logic [3:0] max_idx, min_idx, max_idx1, min_idx1;
    logic [2:0] junk;

    int n_chk;
    int n_fail;

    cmp_minmax_seq_if bus ();
    cmp_minmax_seq_if bus1 ();

    cmp_minmax_seq #(.COUNT(8), .IDX_W(4)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .bus(bus),
        .max_val(max_val), .max_idx(max_idx), .min_val(min_val),
        .min_idx(min_idx), .done(done)
    );

    cmp_minmax_seq #(.COUNT(1), .IDX_W(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .busy(busy1), .bus(bus1),
        .max_val(max_val1), .max_idx(max_idx1), .min_val(min_val1),
        .min_idx(min_idx1), .done(done1)
    );

    // Reference comparator: signed A>B for 1110, signed A<B for 1111, else 0.
    function automatic logic [3:0] cmp_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] op, input logic [2:0] g);
        logic r;
        r = 1'b0;
        if (op == 4'b1110) r = ($signed(a) > $signed(b));
        else if (op == 4'b1111) r = ($signed(a) < $signed(b));
        return {g, r};
    endfunction

    assign bus.cmp_out  = cmp_model(bus.cmp_A, bus.cmp_B, bus.cmp_Opcode, junk);
    assign bus1.cmp_out = cmp_model(bus1.cmp_A, bus1.cmp_B, bus1.cmp_Opcode, ~junk);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) junk <= 3'($urandom);

    typedef struct {
        string       name;
        logic [31:0] ops;        // operand 0 in the top nibble
        logic [7:0]  stall_mask; // bit i: 4 idle LOAD cycles before operand i
        logic        start_hold; // keep start high through the whole job
        logic [3:0]  max_v;
        logic [3:0]  max_i;
        logic [3:0]  min_v;
        logic [3:0]  min_i;
        int          done_cyc;
    } job_t;

    job_t jobs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] op_at(input logic [31:0] ops, input int i);
        return ops[31 - 4*i -: 4];
    endfunction

    task automatic run_job(input job_t j);
        int cyc;
        int idx;
        int stall;
        int cmp_left;
        int done_at;
        logic [3:0] last;
        start = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        cyc = 1;
        if (!j.start_hold) start = 1'b0;
        idx = 0;
        stall = j.stall_mask[0] ? 4 : 0;
        cmp_left = 0;
        done_at = -1;
        last = 4'h0;
        while (done_at < 0 && cyc < 200) begin
            if (done === 1'b1) begin
                done_at = cyc;
            end else begin
                if (cmp_left > 0) begin
                    chk({j.name, " opcode"}, 32'(bus.cmp_Opcode), (cmp_left == 2) ? 32'hE : 32'hF);
                    chk({j.name, " cmp_A"}, 32'(bus.cmp_A), 32'(last));
                    bus.in_valid = 1'b0;
                    cmp_left--;
                end else begin
                    chk({j.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
                    if (stall > 0 || idx >= 8) begin
                        bus.in_valid = 1'b0;
                        if (stall > 0) stall--;
                    end else begin
                        bus.in_valid = 1'b1;
                        bus.in_data  = op_at(j.ops, idx);
                        if (idx > 0) begin
                            cmp_left = 2;
                            last = op_at(j.ops, idx);
                        end
                        idx++;
                        stall = (idx < 8 && j.stall_mask[idx]) ? 4 : 0;
                    end
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        bus.in_valid = 1'b0;
        chk({j.name, " done_cycle"}, 32'(done_at), 32'(j.done_cyc));
        chk({j.name, " max_val"}, 32'(max_val), 32'(j.max_v));
        chk({j.name, " max_idx"}, 32'(max_idx), 32'(j.max_i));
        chk({j.name, " min_val"}, 32'(min_val), 32'(j.min_v));
        chk({j.name, " min_idx"}, 32'(min_idx), 32'(j.min_i));
        tick();
        chk({j.name, " done_pulse"}, 32'(done), 32'd0);
        chk({j.name, " idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        jobs[0] = '{"basic",     32'h3E778051, 8'h00, 1'b0, 4'h7, 4'd2, 4'h8, 4'd4, 23};
        jobs[1] = '{"signed",    32'h87F01234, 8'h00, 1'b0, 4'h7, 4'd1, 4'h8, 4'd0, 23};
        jobs[2] = '{"equal",     32'h55555555, 8'h00, 1'b0, 4'h5, 4'd0, 4'h5, 4'd0, 23};
        jobs[3] = '{"backpress", 32'h3E778051, 8'h22, 1'b0, 4'h7, 4'd2, 4'h8, 4'd4, 31};
        jobs[4] = '{"descend",   32'h76543210, 8'h00, 1'b0, 4'h7, 4'd0, 4'h0, 4'd7, 23};
        jobs[5] = '{"start_busy", 32'h89ABCDEF, 8'h00, 1'b1, 4'hF, 4'd7, 4'h8, 4'd0, 23};

        reset = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 4'h0;
        bus1.in_valid = 1'b0;
        bus1.in_data = 4'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state of both instances.
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst cmp", {20'd0, bus.cmp_A, bus.cmp_B, bus.cmp_Opcode}, 32'd0);
        chk("rst results", {16'd0, max_val, max_idx, min_val, min_idx}, 32'd0);
        chk("rst1 results", {15'd0, busy1, max_val1, max_idx1, min_val1, min_idx1}, 32'd0);

        foreach (jobs[i]) run_job(jobs[i]);

        // Reset during CMP_GT of operand 3 (cycle 9 after start).
        start = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data = 4'h9;
        tick();
        start = 1'b0;
        for (int k = 1; k < 9; k++) tick();
        chk("abort in CMP_GT", 32'(bus.cmp_Opcode), 32'hE);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort cmp", {20'd0, bus.cmp_A, bus.cmp_B, bus.cmp_Opcode}, 32'd0);
        chk("abort results", {15'd0, done, max_val, max_idx, min_val, min_idx}, 32'd0);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("abort stays idle", {30'd0, busy, done}, 32'd0);
        end
        bus.in_valid = 1'b0;

        // Single-operand instance: done two cycles after start.
        start1 = 1'b1;
        bus1.in_valid = 1'b1;
        bus1.in_data = 4'hA;
        tick();
        start1 = 1'b0;
        chk("c1 in_ready", 32'(bus1.in_ready), 32'd1);
        chk("c1 early done", 32'(done1), 32'd0);
        tick();
        bus1.in_valid = 1'b0;
        chk("c1 done", 32'(done1), 32'd1);
        chk("c1 results", {16'd0, max_val1, max_idx1, min_val1, min_idx1}, 32'hA0A0);
        tick();
        chk("c1 done pulse", {30'd0, busy1, done1}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/cmp_minmax_seq.md
Name: cmp_minmax_seq

Overview:
- Sequencer that streams a job of COUNT signed 4-bit operands through the shared Comparator datapath and reports the signed maximum and minimum, with the index of each.
- Drives the Comparator's A, B and Opcode inputs and samples its comp_out. The Comparator is combinational and sits outside this block.
- Sits between an operand source (valid/ready) and the ALU result consumer.

Parameters:
- COUNT, 8, operands per job; legal range 1..15.
- IDX_W, 4, width of the index outputs and of the internal counter; must satisfy 2**IDX_W > COUNT.

Ports:
- clk  in  1  clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  launches a job; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  operand available
- in_data  in  4  operand, two's-complement signed
- in_ready  out  1  high only in LOAD
- cmp_A  out  4  to Comparator A
- cmp_B  out  4  to Comparator B
- cmp_Opcode  out  4  to Comparator Opcode
- cmp_out  in  4  from Comparator comp_out; only bit 0 is used
- max_val  out  4  signed maximum of the last completed job
- max_idx  out  IDX_W  index of max_val within the job, 0-based
- min_val  out  4  signed minimum of the last completed job
- min_idx  out  IDX_W  index of min_val within the job, 0-based
- done  out  1  one-cycle pulse when results are final

Behaviour:
- Reset is synchronous and active-high:
  - state goes to IDLE.
  - max_val, min_val, max_idx, min_idx, the counter and the elem register clear to 0.
  - done, busy and in_ready are 0.
  - cmp_A, cmp_B and cmp_Opcode are 4'b0000.
- Reset asserted mid-job aborts the job; the next job needs a fresh start.
- States: IDLE, LOAD, CMP_GT, CMP_LT, DONE.
- IDLE:
  - cmp_Opcode = 4'b0000, so the Comparator outputs 0.
  - When start = 1: clear the counter and go to LOAD.
  - Results keep their previous values.
- LOAD:
  - in_ready = 1. The operand is accepted on the edge where in_valid & in_ready.
  - Counter == 0 (first operand): max_val = min_val = in_data, max_idx = min_idx = 0. If COUNT == 1, go to DONE; otherwise stay in LOAD.
  - Counter > 0: latch in_data into elem and go to CMP_GT.
  - The counter increments on every accept.
  - If in_valid = 0, stay in LOAD indefinitely; there is no timeout.
- CMP_GT (one cycle):
  - Drive cmp_A = elem, cmp_B = max_val, cmp_Opcode = 4'b1110 (signed A > B).
  - If cmp_out[0] = 1 at the edge: max_val = elem, max_idx = counter - 1.
  - Go to CMP_LT.
- CMP_LT (one cycle):
  - Drive cmp_A = elem, cmp_B = min_val, cmp_Opcode = 4'b1111 (signed A < B).
  - If cmp_out[0] = 1: min_val = elem, min_idx = counter - 1.
  - Go to DONE if counter == COUNT, otherwise go to LOAD.
- DONE:
  - done = 1 for exactly one cycle; results are final; return to IDLE.
  - start asserted in DONE is ignored.
- Ties use strict comparisons, so the earliest index is kept for both max and min.
- cmp_out[3:1] is ignored.
- start is ignored while busy.
- In LOAD and DONE, cmp_Opcode = 4'b0000 and cmp_A = cmp_B = 0.
- Throughput with in_valid held high: the first operand takes 1 cycle; each later operand takes 3 cycles (LOAD, CMP_GT, CMP_LT).
- Latency with in_valid held high: done is asserted 3*COUNT - 1 cycles after the start cycle.
- All outputs are registered except in_ready, busy and cmp_*, which decode from state.

Test Plan:
- Basic job: COUNT=8, start pulse at cycle 0, in_valid held high, data 3, E, 7, 7, 8, 0, 5, 1 (hex) -> done at cycle 23; max_val=4'h7, max_idx=2; min_val=4'h8 (-8), min_idx=4.
- Signed boundary: data 8, 7, F, 0, 1, 2, 3, 4 -> max_val=4'h7, max_idx=1; min_val=4'h8, min_idx=0. The opcode sequence on cmp_Opcode alternates 4'hE then 4'hF per operand.
- All equal: eight operands of 4'h5 -> max_idx=0, min_idx=0, both values 4'h5.
- Backpressure: in_valid low for 4 cycles before operands 1 and 5 -> block stays in LOAD with in_ready=1; results match the basic job; done is delayed by exactly 8 cycles.
- Reset mid-job: assert reset in CMP_GT of operand 3 -> next cycle state is IDLE, all outputs 0, done never pulses.
- start while busy is ignored.
- COUNT=1: a single operand 4'hA -> done 2 cycles after start; max=min=4'hA, both indices 0.
- Comparator mock: the bench drives cmp_out with garbage in bits [3:1] -> results are unaffected.
